// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - CPU-to-memory access sequencer (IDLE/SETUP/ACCESS/DONE)
// Routes each request to chip RAM or external SRAM with per-target wait states.
module mem_seq #(
  parameter logic [15:0] SRAM_BASE = 16'h8000,
  parameter int unsigned SRAM_WAIT = 2,
  parameter int unsigned CHIP_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPUreq,
  input  logic        CPUwe,
  input  logic [15:0] CPUaddr,
  input  logic [15:0] CPUwdata,
  input  logic [1:0]  CPUbe,
  output logic [15:0] CPUrdata,
  output logic        CPUack,
  output logic        CPUbusy,
  output logic [15:0] MEMaddr,
  output logic [15:0] MEMwrite,
  output logic [1:0]  MEMbe,
  output logic        MEMwe,
  output logic        sel,
  input  logic [15:0] MEMread
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SramWait = 4'(SRAM_WAIT);
  localparam logic [3:0] ChipWait = 4'(CHIP_WAIT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [15:0] rdata_q;
  logic        ack_q;
  logic        busy_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        mem_we_q;
  logic        sel_q;
  logic        sram_hit_d;

  assign sram_hit_d = (CPUaddr >= SRAM_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      rdata_q  <= 16'd0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= 16'd0;
      wdata_q  <= 16'd0;
      be_q     <= 2'b00;
      mem_we_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q    <= 1'b0;
          mem_we_q <= 1'b0;
          if (CPUreq) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            addr_q  <= CPUaddr;
            wdata_q <= CPUwdata;
            we_q    <= CPUwe;
            // Reads always fetch the full word; byte lanes only matter on writes.
            be_q    <= CPUwe ? CPUbe : 2'b11;
            sel_q   <= sram_hit_d;
          end else begin
            busy_q <= 1'b0;
            be_q   <= 2'b00;
            sel_q  <= 1'b0;
          end
        end
        SETUP: begin
          state_q  <= ACCESS;
          cnt_q    <= sel_q ? SramWait : ChipWait;
          mem_we_q <= we_q;
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q  <= DONE;
            mem_we_q <= 1'b0;
            ack_q    <= 1'b1;
            if (!we_q) begin
              rdata_q <= MEMread;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
          be_q    <= 2'b00;
          sel_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CPUrdata = rdata_q;
  assign CPUack   = ack_q;
  assign CPUbusy  = busy_q;
  assign MEMaddr  = addr_q;
  assign MEMwrite = wdata_q;
  assign MEMbe    = be_q;
  assign MEMwe    = mem_we_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - self-checking bench for mem_seq
// Transaction-timeline model plus directed vectors with literal expectations.
module tb_mem_seq;

  localparam logic [15:0] BASE = 16'h8000;
  localparam int SW = 2;
  localparam int CW = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPUreq = 1'b0;
  logic        CPUwe = 1'b0;
  logic [15:0] CPUaddr = 16'd0;
  logic [15:0] CPUwdata = 16'd0;
  logic [1:0]  CPUbe = 2'b00;
  logic [15:0] CPUrdata;
  logic        CPUack;
  logic        CPUbusy;
  logic [15:0] MEMaddr;
  logic [15:0] MEMwrite;
  logic [1:0]  MEMbe;
  logic        MEMwe;
  logic        sel;
  logic [15:0] MEMread = 16'd0;

  int n_assert = 0;
  int n_fail = 0;

  mem_seq #(.SRAM_BASE(BASE), .SRAM_WAIT(SW), .CHIP_WAIT(CW)) dut (
    .clk(clk), .rst(rst), .CPUreq(CPUreq), .CPUwe(CPUwe), .CPUaddr(CPUaddr),
    .CPUwdata(CPUwdata), .CPUbe(CPUbe), .CPUrdata(CPUrdata), .CPUack(CPUack),
    .CPUbusy(CPUbusy), .MEMaddr(MEMaddr), .MEMwrite(MEMwrite), .MEMbe(MEMbe),
    .MEMwe(MEMwe), .sel(sel), .MEMread(MEMread)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the number of edges since (and counting) the accepting edge,
  // 0 when idle; a transaction occupies m_t = 1 .. m_lat with m_lat = wait + 3.
  int          m_t, m_lat;
  logic        m_we, m_sel;
  logic [1:0]  m_be;
  logic [15:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0; m_lat <= 0; m_we <= 1'b0; m_sel <= 1'b0; m_be <= 2'b00;
      m_addr <= 16'd0; m_wdata <= 16'd0; m_rdata <= 16'd0;
    end else if (m_t == 0) begin
      if (CPUreq) begin
        m_t     <= 1;
        m_lat   <= ((CPUaddr >= BASE) ? SW : CW) + 3;
        m_we    <= CPUwe;
        m_sel   <= (CPUaddr >= BASE);
        m_be    <= CPUbe;
        m_addr  <= CPUaddr;
        m_wdata <= CPUwdata;
      end
    end else begin
      m_t <= (m_t == m_lat) ? 0 : m_t + 1;
      if (m_t == m_lat - 1 && !m_we) m_rdata <= MEMread;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", CPUbusy, m_t != 0);
      chk("ack", CPUack, m_t != 0 && m_t == m_lat);
      chk("memwe", MEMwe, m_we && m_t >= 2 && m_t <= m_lat - 1);
      chk("sel", sel, m_t != 0 && m_sel);
      chk("membe", MEMbe, (m_t == 0) ? 2'b00 : (m_we ? m_be : 2'b11));
      chk("memaddr", MEMaddr, m_addr);
      chk("memwrite", MEMwrite, m_wdata);
      chk("rdata", CPUrdata, m_rdata);
    end
  end

  task automatic xact(input logic we, input logic [15:0] a, input logic [15:0] wd,
                      input logic [1:0] be, input logic [15:0] rd, input bit hold,
                      input bit pulse, input logic e_sel, input logic [1:0] e_be,
                      input int e_lat, input int e_wec, input logic [15:0] e_rdata);
    int n, wec;
    n = 0;
    wec = 0;
    @(negedge clk);
    CPUreq = 1'b1; CPUwe = we; CPUaddr = a; CPUwdata = wd; CPUbe = be; MEMread = rd;
    @(posedge clk);
    @(negedge clk);
    CPUreq = hold;
    chk("setup_sel", sel, e_sel);
    chk("setup_be", MEMbe, e_be);
    if (MEMwe) wec++;
    while (!CPUack && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (MEMwe) wec++;
      if (pulse) CPUreq = (n == 2);
    end
    if (!hold) CPUreq = 1'b0;
    chk("latency", n, e_lat);
    chk("we_cycles", wec, e_wec);
    chk("rdata_after", CPUrdata, e_rdata);
  endtask

  initial begin
    #1;
    chk("rst_rdata", CPUrdata, 16'd0);
    chk("rst_outs", {CPUack, CPUbusy, MEMwe, sel, MEMbe, MEMaddr, MEMwrite}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xact(1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 0, 0, 1'b0, 2'b11, 2, 0, 16'hBEEF);
    xact(1'b1, 16'h8000, 16'h1234, 2'b01, 16'h0000, 0, 0, 1'b1, 2'b01, 4, 3, 16'hBEEF);
    xact(1'b0, 16'h7FFF, 16'h0000, 2'b00, 16'h1111, 0, 0, 1'b0, 2'b11, 2, 0, 16'h1111);
    xact(1'b0, 16'h8000, 16'h0000, 2'b10, 16'h2222, 0, 0, 1'b1, 2'b11, 4, 0, 16'h2222);
    xact(1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h3333, 0, 0, 1'b1, 2'b11, 4, 0, 16'h3333);
    xact(1'b1, 16'h0020, 16'hAAAA, 2'b00, 16'h9999, 0, 0, 1'b0, 2'b00, 2, 1, 16'h3333);
    xact(1'b1, 16'h0030, 16'h5A5A, 2'b11, 16'h0000, 1, 0, 1'b0, 2'b11, 2, 1, 16'h3333);
    xact(1'b0, 16'h9000, 16'h0000, 2'b00, 16'h4444, 0, 0, 1'b1, 2'b11, 4, 0, 16'h4444);
    xact(1'b1, 16'h8004, 16'h7777, 2'b10, 16'h0000, 0, 1, 1'b1, 2'b10, 4, 3, 16'h4444);
    repeat (2) @(negedge clk);
    chk("idle_after_pulse", CPUbusy, 1'b0);

    // Abort an SRAM write while MEMwe is high, mid-cycle.
    @(negedge clk);
    CPUreq = 1'b1; CPUwe = 1'b1; CPUaddr = 16'hC000; CPUwdata = 16'hDEAD; CPUbe = 2'b11;
    @(posedge clk);
    @(negedge clk);
    CPUreq = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_abort_we", MEMwe, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_we", MEMwe, 1'b0);
    chk("abort_outs", {CPUack, CPUbusy, sel, MEMbe, MEMaddr, MEMwrite}, 32'd0);
    chk("abort_rdata", CPUrdata, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", CPUack, 1'b0);
    end
    xact(1'b0, 16'h0040, 16'h0000, 2'b00, 16'h5555, 0, 0, 1'b0, 2'b11, 2, 0, 16'h5555);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter SRAM_BASE, 16'h8000, lowest address routed to external SRAM; addresses below it go to chip RAM.
REQ-002 Parameter SRAM_WAIT, 2, extra ACCESS cycles for SRAM transactions (0..15).
REQ-003 Parameter CHIP_WAIT, 0, extra ACCESS cycles for chip-RAM transactions (0..15).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 CPUreq  in  1  level request; sampled only in IDLE.
REQ-008 CPUwe  in  1  1 = write, 0 = read.
REQ-009 CPUaddr  in  16  word address.
REQ-010 CPUwdata  in  16  write data.
REQ-011 CPUbe  in  2  byte enables for writes; [0] = low byte.
REQ-012 CPUrdata  out  16  read data, registered.
REQ-013 CPUack  out  1  one-cycle completion pulse.
REQ-014 CPUbusy  out  1  high whenever state is not IDLE.
REQ-015 MEMaddr  out  16  latched address to chip RAM / SRAM.
REQ-016 MEMwrite  out  16  latched write data to the RAM switch.
REQ-017 MEMbe  out  2  byte enables to the RAM switch.
REQ-018 MEMwe  out  1  write strobe to the RAM switch.
REQ-019 sel  out  1  target select: 1 = SRAM, 0 = chip RAM.
REQ-020 MEMread  in  16  read data returned by the RAM switch.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, ACCESS, DONE; all outputs SHALL be registered.
REQ-022 IDLE: on a clock edge with CPUreq=1, SHALL latch CPUaddr, CPUwdata, CPUbe, CPUwe, set sel = (CPUaddr >= SRAM_BASE), and go to SETUP; otherwise stay in IDLE.
REQ-023 SETUP lasts one cycle: MEMaddr, MEMwrite, MEMbe and sel SHALL be stable; MEMwe SHALL be 0. Wait counter SHALL load SRAM_WAIT if sel=1, else CHIP_WAIT. Next state is ACCESS.
REQ-024 ACCESS: MEMwe SHALL equal the latched CPUwe. While the counter is nonzero it SHALL decrement each edge. At an edge with counter=0 the FSM SHALL go to DONE, and on reads SHALL capture MEMread into CPUrdata. ACCESS therefore lasts WAIT+1 cycles.
REQ-025 DONE lasts one cycle: MEMwe=0, CPUack=1. Address, be and sel SHALL be held. Next state is IDLE.
REQ-026 Latency: CPUack SHALL be high in the cycle following the (WAIT+3)th rising edge after, and counting, the accepting edge.
REQ-027 Reads SHALL drive MEMbe=2'b11 regardless of CPUbe. Writes SHALL drive MEMbe=latched CPUbe.
REQ-028 A write with CPUbe=2'b00 SHALL run the full sequence, with MEMwe pulsed and no byte enabled, and SHALL be acknowledged.
REQ-029 In IDLE: MEMwe=0, MEMbe=2'b00, sel=0; MEMaddr and MEMwrite SHALL hold their last values.
REQ-030 CPUreq in SETUP, ACCESS or DONE SHALL be ignored. A CPUreq still high in the IDLE cycle after DONE SHALL start a new transaction, so requesters drop CPUreq in the ack cycle.
REQ-031 CPUrdata SHALL change only at read completion and SHALL hold across writes and idle cycles.
REQ-032 Address exactly SRAM_BASE SHALL select SRAM. Address SRAM_BASE-1 SHALL select chip RAM. Address 16'hFFFF SHALL select SRAM.

Reset
REQ-033 Asserting rst SHALL immediately force state to IDLE and set CPUrdata=0, CPUack=0, CPUbusy=0, MEMaddr=0, MEMwrite=0, MEMbe=0, MEMwe=0, sel=0, and wait counter=0.
REQ-034 Reset during ACCESS SHALL drop MEMwe without waiting for a clock edge. The aborted transaction SHALL never be acknowledged.
REQ-035 After rst deasserts, the first edge with CPUreq=1 SHALL be accepted normally.

Verification
REQ-036 Chip read: CPUaddr=16'h0010, CPUwe=0, MEMread=16'hBEEF, CHIP_WAIT=0 -> sel=0, MEMbe=11, CPUack 2 edges after the accepting edge, CPUrdata=16'hBEEF.
REQ-037 SRAM write: CPUaddr=16'h8000, CPUwdata=16'h1234, CPUbe=01, SRAM_WAIT=2 -> sel=1, MEMbe=01, MEMwe high for exactly 3 cycles, CPUack 4 edges after the accepting edge.
REQ-038 Boundary decode: reads at 16'h7FFF and then 16'h8000 -> sel=0 for the first and sel=1 for the second, each with correct latency.
REQ-039 Back-to-back: hold CPUreq high through the ack -> second transaction starts in the following IDLE cycle. A pulse on CPUreq during ACCESS -> ignored.
REQ-040 Reset mid-ACCESS of an SRAM write -> MEMwe=0 and all outputs zero before the next edge, no CPUack; a subsequent read completes normally.
REQ-041 Zero-enable write: CPUbe=00 -> MEMbe=00, MEMwe pulses, CPUack asserted, CPUrdata unchanged.
